// File: rtl/cvt_pkg.sv
// Shared types and constants for the cvt9to16 converter schedulers.
// Holds the arbiter state encoding, the converter input geometry and a
// helper that clamps a beat's valid-bit count to what the converter takes.
package cvt_pkg;

  localparam int CVT_IN_W   = 9;
  localparam int CVT_VB_W   = 4;
  localparam int CVT_VB_MAX = 9;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FLUSH
  } arb_state_e;

  // Counts above the converter input width are meaningless, so they saturate.
  // A count of 0 is passed through untouched.
  function automatic logic [CVT_VB_W-1:0] clamp_vb(input logic [CVT_VB_W-1:0] vb);
    logic [CVT_VB_W-1:0] vb_max;
    vb_max = CVT_VB_W'(CVT_VB_MAX);
    return (vb > vb_max) ? vb_max : vb;
  endfunction

endpackage

// File: rtl/cvt_pkt_arbiter_rr_pick.sv
// Combinational round-robin selector. Returns the first eligible requester
// strictly after last_gid, wrapping around, plus a flag saying whether any
// requester was eligible at all. Shared by the converter schedulers.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [GID_W-1:0] last_gid,
  output logic [GID_W-1:0] winner,
  output logic             any
);

  // Scan from the farthest candidate towards the nearest so the closest
  // eligible requester after last_gid is the final assignment to stick.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_gid) + k) % N_REQ;
      if (eligible[idx]) begin
        winner = GID_W'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cvt_pkt_arbiter.sv
// Round-robin packet arbiter in front of the cvt9to16 width converter.
// A whole packet (sop..eop) is granted to one requester, its beats are
// forwarded one cycle later on registered outputs, and after each eop the
// arbiter idles FLUSH_CYCLES cycles so the converter can drain its partial
// word. Orphan beats (valid without sop while idle) are accepted and dropped.
// Optional feature: define CVT_ARB_PKT_CNT_EN to add pkt_cnt, a per-requester
// 16-bit count of completed packets.
module cvt_pkt_arbiter
  import cvt_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int FLUSH_CYCLES = 3,
  localparam int GID_W        = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_REQ*CVT_IN_W-1:0]    req_data,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_sop,
  input  logic [N_REQ-1:0]             req_eop,
  input  logic [N_REQ*CVT_VB_W-1:0]    req_valid_bits,
  output logic [N_REQ-1:0]             req_ready,
  output logic [CVT_IN_W-1:0]          data_in,
  output logic                         data_in_valid,
  output logic                         data_in_sop,
  output logic                         data_in_eop,
  output logic [CVT_VB_W-1:0]          data_in_valid_bits,
  output logic [GID_W-1:0]             grant_id,
`ifdef CVT_ARB_PKT_CNT_EN
  output logic [N_REQ*16-1:0]          pkt_cnt,
`endif
  output logic                         busy,
  output logic                         err_drop
);

  arb_state_e state;
  arb_state_e state_nxt;

  logic [GID_W-1:0]    last_gid;
  logic [GID_W-1:0]    pick_id;
  logic                pick_any;
  logic [3:0]          flush_cnt;
  logic                first_beat;

  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    orphan;

  logic                g_valid;
  logic                g_sop;
  logic                g_eop;
  logic [CVT_IN_W-1:0] g_data;
  logic [CVT_VB_W-1:0] g_vb;
  logic                accept;

  assign eligible = req_valid & req_sop;
  assign orphan   = req_valid & ~req_sop;

  assign g_valid  = req_valid[grant_id];
  assign g_sop    = req_sop[grant_id];
  assign g_eop    = req_eop[grant_id];
  assign g_data   = req_data[grant_id*CVT_IN_W +: CVT_IN_W];
  assign g_vb     = req_valid_bits[grant_id*CVT_VB_W +: CVT_VB_W];
  assign accept   = (state == XFER) && g_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .GID_W (GID_W)
  ) u_rr_pick (
    .eligible (eligible),
    .last_gid (last_gid),
    .winner   (pick_id),
    .any      (pick_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: grant from IDLE, leave XFER on an accepted eop, leave FLUSH
  // when the drain counter is on its last cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_any) state_nxt = XFER;
      end
      XFER: begin
        if (accept && g_eop) state_nxt = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
      end
      FLUSH: begin
        if (flush_cnt <= 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs: only the owner is ready in XFER; in IDLE only orphan
  // beats are taken (to be discarded); nothing is taken while flushing.
  always_comb begin
    req_ready = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    req_ready = orphan;
      XFER:    req_ready[grant_id] = 1'b1;
      default: req_ready = '0;
    endcase
  end

  // Grant bookkeeping, drain counter and the registered converter-side beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_id           <= '0;
      last_gid           <= GID_W'(N_REQ - 1);
      first_beat         <= 1'b0;
      flush_cnt          <= '0;
      data_in            <= '0;
      data_in_valid      <= 1'b0;
      data_in_sop        <= 1'b0;
      data_in_eop        <= 1'b0;
      data_in_valid_bits <= '0;
      err_drop           <= 1'b0;
    end else begin
      data_in_valid      <= accept;
      data_in            <= accept ? g_data : '0;
      data_in_sop        <= accept && g_sop && first_beat;
      data_in_eop        <= accept && g_eop;
      data_in_valid_bits <= accept ? clamp_vb(g_vb) : '0;
      err_drop           <= (state == IDLE) && (|orphan);

      if (state == IDLE && pick_any) begin
        grant_id   <= pick_id;
        first_beat <= 1'b1;
      end

      if (accept) begin
        first_beat <= 1'b0;
        if (g_eop) begin
          last_gid  <= grant_id;
          flush_cnt <= 4'(FLUSH_CYCLES);
        end
      end else if (state == FLUSH && flush_cnt != 4'd0) begin
        flush_cnt <= flush_cnt - 4'd1;
      end
    end
  end

`ifdef CVT_ARB_PKT_CNT_EN
  // Completed-packet counters, bumped on every accepted eop and wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_cnt <= '0;
    end else if (accept && g_eop) begin
      pkt_cnt[grant_id*16 +: 16] <= pkt_cnt[grant_id*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cvt_pkt_arbiter.sv
// Self-checking bench for cvt_pkt_arbiter. A packet-level reference model
// tracks ownership and drain time, the compare process checks every output
// each cycle, and directed tests pin the model with hand-computed values.
module tb_cvt_pkt_arbiter;
  import cvt_pkg::*;

  localparam int N_REQ        = 4;
  localparam int FLUSH_CYCLES = 3;
  localparam int GID_W        = $clog2(N_REQ);

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic [N_REQ*9-1:0]        req_data;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_sop;
  logic [N_REQ-1:0]          req_eop;
  logic [N_REQ*4-1:0]        req_valid_bits;
  logic [N_REQ-1:0]          req_ready;
  logic [8:0]                data_in;
  logic                      data_in_valid;
  logic                      data_in_sop;
  logic                      data_in_eop;
  logic [3:0]                data_in_valid_bits;
  logic [GID_W-1:0]          grant_id;
  logic                      busy;
  logic                      err_drop;
`ifdef CVT_ARB_PKT_CNT_EN
  logic [N_REQ*16-1:0]       pkt_cnt;
`endif

  logic       s_valid [N_REQ];
  logic       s_sop   [N_REQ];
  logic       s_eop   [N_REQ];
  logic [8:0] s_data  [N_REQ];
  logic [3:0] s_vb    [N_REQ];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i]           = s_valid[i];
      req_sop[i]             = s_sop[i];
      req_eop[i]             = s_eop[i];
      req_data[i*9 +: 9]     = s_data[i];
      req_valid_bits[i*4 +: 4] = s_vb[i];
    end
  end

  cvt_pkt_arbiter #(
    .N_REQ        (N_REQ),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .req_data           (req_data),
    .req_valid          (req_valid),
    .req_sop            (req_sop),
    .req_eop            (req_eop),
    .req_valid_bits     (req_valid_bits),
    .req_ready          (req_ready),
    .data_in            (data_in),
    .data_in_valid      (data_in_valid),
    .data_in_sop        (data_in_sop),
    .data_in_eop        (data_in_eop),
    .data_in_valid_bits (data_in_valid_bits),
    .grant_id           (grant_id),
`ifdef CVT_ARB_PKT_CNT_EN
    .pkt_cnt            (pkt_cnt),
`endif
    .busy               (busy),
    .err_drop           (err_drop)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: owner of the current packet (-1 when none), remaining
  // drain cycles, and the expected registered outputs for this cycle.
  typedef struct {
    logic [8:0] d;
    logic       s;
    logic       e;
    logic [3:0] vb;
    int         cyc;
    int         gid;
  } beat_t;

  int          owner = -1;
  int          cooldown = 0;
  int          mlast = N_REQ - 1;
  bit          first = 1'b0;
  int          cyc = 0;
  bit          checking = 1'b0;
  logic [8:0]  e_data = '0;
  logic        e_valid = 1'b0;
  logic        e_sop = 1'b0;
  logic        e_eop = 1'b0;
  logic [3:0]  e_vb = '0;
  logic        e_err = 1'b0;
  int          e_gid = 0;
  logic [15:0] m_cnt [N_REQ];

  beat_t beat_q[$];
  int    sop_cyc[$];
  int    sop_gid[$];
  int    eop_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      owner    = -1;
      cooldown = 0;
      mlast    = N_REQ - 1;
      first    = 1'b0;
      e_data   = '0; e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_vb = '0; e_err = 1'b0;
      e_gid    = 0;
      for (int i = 0; i < N_REQ; i++) m_cnt[i] = '0;
      checking = 1'b1;
    end else begin
      e_data = '0; e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_vb = '0; e_err = 1'b0;
      if (owner < 0 && cooldown == 0) begin
        for (int i = 0; i < N_REQ; i++)
          if (req_valid[i] && !req_sop[i]) e_err = 1'b1;
        for (int k = 1; k <= N_REQ; k++) begin
          int idx;
          idx = (mlast + k) % N_REQ;
          if (owner < 0 && req_valid[idx] && req_sop[idx]) begin
            owner = idx;
            e_gid = idx;
            first = 1'b1;
          end
        end
      end else if (owner >= 0) begin
        if (req_valid[owner]) begin
          beat_t b;
          e_valid = 1'b1;
          e_data  = s_data[owner];
          e_sop   = first && req_sop[owner];
          e_eop   = req_eop[owner];
          e_vb    = (s_vb[owner] > 4'd9) ? 4'd9 : s_vb[owner];
          first   = 1'b0;
          b.d = e_data; b.s = e_sop; b.e = e_eop; b.vb = e_vb; b.cyc = cyc; b.gid = owner;
          beat_q.push_back(b);
          if (e_sop) begin sop_cyc.push_back(cyc); sop_gid.push_back(owner); end
          if (e_eop) begin
            eop_cyc.push_back(cyc);
            m_cnt[owner] = m_cnt[owner] + 16'd1;
            mlast    = owner;
            cooldown = FLUSH_CYCLES;
            owner    = -1;
          end
        end
      end else begin
        cooldown--;
      end
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      logic [N_REQ-1:0] er;
      er = '0;
      if (owner >= 0) er[owner] = 1'b1;
      else if (cooldown == 0) er = req_valid & ~req_sop;
      checkOutput("req_ready", 64'(req_ready), 64'(er));
      checkOutput("data_in_valid", 64'(data_in_valid), 64'(e_valid));
      checkOutput("data_in", 64'(data_in), 64'(e_data));
      checkOutput("data_in_sop", 64'(data_in_sop), 64'(e_sop));
      checkOutput("data_in_eop", 64'(data_in_eop), 64'(e_eop));
      checkOutput("data_in_valid_bits", 64'(data_in_valid_bits), 64'(e_vb));
      checkOutput("grant_id", 64'(grant_id), 64'(e_gid));
      checkOutput("busy", 64'(busy), 64'(owner >= 0 || cooldown > 0));
      checkOutput("err_drop", 64'(err_drop), 64'(e_err));
`ifdef CVT_ARB_PKT_CNT_EN
      for (int i = 0; i < N_REQ; i++)
        checkOutput("pkt_cnt", 64'(pkt_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    beat_q.delete();
    sop_cyc.delete();
    sop_gid.delete();
    eop_cyc.delete();
  endtask

  task automatic applyStimulus(input int r, input logic v, input logic s, input logic e,
                               input logic [8:0] d, input logic [3:0] vb);
    s_valid[r] = v;
    s_sop[r]   = s;
    s_eop[r]   = e;
    s_data[r]  = d;
    s_vb[r]    = vb;
  endtask

  // Present one beat and hold it until the arbiter takes it (bounded wait).
  task automatic sendBeat(input int r, input logic [8:0] d, input logic [3:0] vb,
                          input logic s, input logic e);
    int waited;
    applyStimulus(r, 1'b1, s, e, d, vb);
    waited = 0;
    forever begin
      @(negedge clk);
      if (req_ready[r]) break;
      waited++;
      if (waited > 64) begin
        checks++;
        errors++;
        $display("[TB] FAIL handshake_timeout req=%0d actual=not_ready required=ready", r);
        break;
      end
    end
    tick();
    s_valid[r] = 1'b0;
  endtask

  task automatic sendPacket(input int r, input int n, input logic [8:0] d0, input logic [3:0] vb,
                            input int gap, input bit allsop);
    for (int b = 0; b < n; b++) begin
      sendBeat(r, 9'(d0 + 9'(b)), vb, allsop || (b == 0), b == n - 1);
      if (b < n - 1) repeat (gap) tick();
    end
  endtask

  task automatic resetPulse();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0, 9'h000, 4'd0);

    // Reset state
    repeat (2) tick();
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("rst_valid", 64'(data_in_valid), 64'd0);
    checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    tick();

    // Three-beat packet from requester 0
    clearLog();
    sendBeat(0, 9'h1FF, 4'd9, 1'b1, 1'b0);
    sendBeat(0, 9'h0AA, 4'd9, 1'b0, 1'b0);
    sendBeat(0, 9'h155, 4'd9, 1'b0, 1'b1);
    repeat (FLUSH_CYCLES + 3) tick();
    checkOutput("t1_beats", 64'(beat_q.size()), 64'd3);
    if (beat_q.size() == 3) begin
      checkOutput("t1_b0", {beat_q[0].s, beat_q[0].e, beat_q[0].d}, {1'b1, 1'b0, 9'h1FF});
      checkOutput("t1_b1", {beat_q[1].s, beat_q[1].e, beat_q[1].d}, {1'b0, 1'b0, 9'h0AA});
      checkOutput("t1_b2", {beat_q[2].s, beat_q[2].e, beat_q[2].d}, {1'b0, 1'b1, 9'h155});
      checkOutput("t1_gid", 64'(beat_q[2].gid), 64'd0);
    end

    // Contention between requesters 0, 1, 2
    resetPulse();
    clearLog();
    fork
      begin
        sendPacket(0, 2, 9'h010, 4'd9, 0, 1'b0);
        sendPacket(0, 2, 9'h040, 4'd9, 0, 1'b0);
      end
      sendPacket(1, 2, 9'h020, 4'd9, 0, 1'b0);
      sendPacket(2, 2, 9'h030, 4'd9, 0, 1'b0);
    join
    repeat (FLUSH_CYCLES + 3) tick();
    checkOutput("t2_npkt", 64'(sop_gid.size()), 64'd4);
    if (sop_gid.size() == 4 && eop_cyc.size() == 4) begin
      checkOutput("t2_order", {sop_gid[0][7:0], sop_gid[1][7:0], sop_gid[2][7:0], sop_gid[3][7:0]},
                  {8'd0, 8'd1, 8'd2, 8'd0});
      for (int i = 1; i < 4; i++)
        checkOutput("t2_gap", 64'(sop_cyc[i] - eop_cyc[i-1]), 64'd5);
    end

    // Single-beat packet, requester 1
    clearLog();
    sendPacket(1, 1, 9'h033, 4'd4, 0, 1'b0);
    repeat (FLUSH_CYCLES + 3) tick();
    checkOutput("t3_beats", 64'(beat_q.size()), 64'd1);
    if (beat_q.size() == 1)
      checkOutput("t3_b0", {beat_q[0].s, beat_q[0].e, beat_q[0].vb, beat_q[0].d},
                  {1'b1, 1'b1, 4'd4, 9'h033});

    // Orphan beat on requester 3
    clearLog();
    applyStimulus(3, 1'b1, 1'b0, 1'b0, 9'h0F0, 4'd9);
    @(negedge clk);
    checkOutput("t4_ready", 64'(req_ready[3]), 64'd1);
    tick();
    s_valid[3] = 1'b0;
    @(negedge clk);
    checkOutput("t4_err", 64'(err_drop), 64'd1);
    tick();
    checkOutput("t4_nobeat", 64'(beat_q.size()), 64'd0);

    // Stalled requester, repeated sop and vb 0
    clearLog();
    sendPacket(3, 2, 9'h0C0, 4'd0, 2, 1'b1);
    repeat (FLUSH_CYCLES + 3) tick();
    checkOutput("t5_beats", 64'(beat_q.size()), 64'd2);
    if (beat_q.size() == 2) begin
      checkOutput("t5_sop", {beat_q[0].s, beat_q[1].s}, 2'b10);
      checkOutput("t5_vb", 64'(beat_q[1].vb), 64'd0);
      checkOutput("t5_spacing", 64'(beat_q[1].cyc - beat_q[0].cyc), 64'd3);
    end

    // Reset during beat 2 of a packet from requester 1
    sendBeat(1, 9'h101, 4'd9, 1'b1, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 9'h102, 4'd9);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    s_valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("t6_valid", 64'(data_in_valid), 64'd0);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_grant_id", 64'(grant_id), 64'd0);
    tick();
    clearLog();
    fork
      sendPacket(0, 2, 9'h050, 4'd9, 0, 1'b0);
      sendPacket(2, 2, 9'h060, 4'd9, 0, 1'b0);
    join
    repeat (FLUSH_CYCLES + 3) tick();
    checkOutput("t6_npkt", 64'(sop_gid.size()), 64'd2);
    if (sop_gid.size() >= 1) checkOutput("t6_first", 64'(sop_gid[0]), 64'd0);

    // Oversized valid-bit count
    clearLog();
    sendPacket(2, 1, 9'h0AB, 4'd12, 0, 1'b0);
    repeat (FLUSH_CYCLES + 3) tick();
    checkOutput("t7_beats", 64'(beat_q.size()), 64'd1);
    if (beat_q.size() == 1) checkOutput("t7_vb", 64'(beat_q[0].vb), 64'd9);
`ifdef CVT_ARB_PKT_CNT_EN
    checkOutput("t7_cnt2", 64'(m_cnt[2]), 64'd2);
    checkOutput("t7_cnt0", 64'(m_cnt[0]), 64'd1);
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cvt_pkt_arbiter.md
# cvt_pkt_arbiter

Round-robin packet arbiter that shares one 9-bit-in width converter (cvt9to16) between N packet sources. It grants a whole packet (sop..eop) to one requester, forwards its beats unmodified on a registered output, then holds off new grants for a programmable flush gap so the converter can drain its residual partial word. It sits directly upstream of the converter's data_in port.

## Interface
- N_REQ, 4: number of requesters, 2..8
- FLUSH_CYCLES, 3: idle cycles inserted after each eop beat, 0..15
- GID_W, $clog2(N_REQ): grant id width (localparam)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is synchronous and active-low
- req_data  in  N_REQ*9  requester i data at [i*9+:9]
- req_valid  in  N_REQ  beat valid per requester
- req_sop  in  N_REQ  start of packet per requester
- req_eop  in  N_REQ  end of packet per requester
- req_valid_bits  in  N_REQ*4  valid bits of beat, MSB-aligned, at [i*4+:4]
- req_ready  out  N_REQ  beat accepted when valid & ready
- data_in  out  9  to converter
- data_in_valid  out  1  to converter
- data_in_sop  out  1  to converter
- data_in_eop  out  1  to converter
- data_in_valid_bits  out  4  to converter, range 0..9
- grant_id  out  GID_W  requester owning the current or last packet
- busy  out  1  state != IDLE
- err_drop  out  1  one-cycle pulse: orphan beat discarded

## Operation
- States: IDLE, XFER, FLUSH.
- IDLE: eligible[i] = req_valid[i] & req_sop[i]. If any eligible, pick first eligible strictly after last_gid (wrapping), register grant_id, go XFER. req_ready = 0 for eligible requesters.
- IDLE orphan: requester with req_valid & ~req_sop gets req_ready = 1 that cycle; beat discarded, err_drop = 1. Orphans are discarded even while another requester is being granted.
- XFER: req_ready[grant_id] = 1, all others 0. Each accepted beat is forwarded next cycle. req_sop on non-first beat forwarded as 0. Accepted beat with eop: go FLUSH (or IDLE if FLUSH_CYCLES = 0), last_gid <= grant_id.
- Single-beat packet (sop & eop) is legal: one forwarded beat with both flags.
- FLUSH: down-counter loaded with FLUSH_CYCLES on eop, decrement per cycle, go IDLE when it reaches 1. All req_ready = 0.
- valid_bits > 9 are clamped to 9 on output; 0 forwarded as-is (converter ignores it).
- Requester dropping valid mid-packet: arbiter waits in XFER indefinitely (no timeout); output data_in_valid = 0 for those cycles.
- last_gid resets to N_REQ-1 so requester 0 wins the first arbitration.

## Timing
- Reset (rstn = 0 at a clk edge): state IDLE, all outputs 0, grant_id 0, counters 0. Mid-packet reset abandons the packet; no eop is emitted.
- req_ready is combinational from registered state/grant_id only (no path from req_valid except orphan drop in IDLE).
- Latency: accepted beat at cycle t appears on data_in_* at t+1.
- Grant: eligible request at cycle t (IDLE) -> XFER at t+1 -> first beat accepted at t+1 earliest.
- Back-to-back packets, same or different requester: minimum gap between eop out and next sop out = FLUSH_CYCLES + 2 cycles.

## Configuration
- CVT_ARB_PKT_CNT_EN defined: adds output pkt_cnt (N_REQ*16), a per-requester count of completed packets (incremented on accepted eop, wraps at 16'hFFFF, reset to 0).
- Undefined: port and counters absent; all other behaviour identical.

## Structure
- Package cvt_pkg: typedef enum arb_state_e {IDLE, XFER, FLUSH}; localparam CVT_IN_W = 9, CVT_VB_W = 4, CVT_VB_MAX = 9.
- Sub-module rr_pick: combinational round-robin selector (eligible vector, last_gid -> winner id, any), reusable by other converter schedulers.

## Test plan
- Reset, then req 0 sends 3-beat packet data 0x1FF/0x0AA/0x155, vb 9 -> same beats on data_in one cycle after acceptance, sop on beat 1, eop on beat 3, grant_id 0.
- Reqs 0,1,2 all hold sop continuously, FLUSH_CYCLES 3 -> grants 0,1,2,0, eop-to-sop gap exactly 5 cycles.
- Req 1 single-beat sop&eop, vb 4 -> one output beat, sop=eop=1, valid_bits 4, then FLUSH.
- Req 3 presents valid without sop in IDLE -> req_ready[3]=1, err_drop pulse, nothing on data_in.
- rstn low during beat 2 of a packet -> next cycle all outputs 0, state IDLE; req 0 wins next arbitration.
- vb 12 on input -> data_in_valid_bits 9; with CVT_ARB_PKT_CNT_EN, pkt_cnt[i] increments per eop.
